// File: rtl/uscope_dma_sink.sv
// uscope_dma_sink: AXI-lite S2MM register subset plus an AXI-stream sink that writes beats to memory.
// Optional: define USCOPE_DMA_SINK_TLAST_CHECK_EN to end frames on tlast and flag length mismatches.
module uscope_dma_sink #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LENGTH_WIDTH = 26
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           ctrl_awaddr,
  input  logic                  ctrl_awvalid,
  output logic                  ctrl_awready,
  input  logic [31:0]           ctrl_wdata,
  input  logic                  ctrl_wvalid,
  output logic                  ctrl_wready,
  output logic [1:0]            ctrl_bresp,
  output logic                  ctrl_bvalid,
  input  logic                  ctrl_bready,
  input  logic [31:0]           ctrl_araddr,
  input  logic                  ctrl_arvalid,
  output logic                  ctrl_arready,
  output logic [31:0]           ctrl_rdata,
  output logic [1:0]            ctrl_rresp,
  output logic                  ctrl_rvalid,
  input  logic                  ctrl_rready,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  in_tlast,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  dma_done,
  output logic                  irq
);

  localparam int BEAT_WIDTH = LENGTH_WIDTH - 1;

  localparam logic [1:0] ST_HALTED   = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_TRANSFER = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [6:0] REG_DMACR  = 7'h30;
  localparam logic [6:0] REG_DMASR  = 7'h34;
  localparam logic [6:0] REG_DA     = 7'h48;
  localparam logic [6:0] REG_LENGTH = 7'h58;

  logic [1:0]              state;
  logic                    dmacr_rs, dmacr_ioc_en;
  logic                    dmasr_int_err, dmasr_ioc_irq;
  logic [ADDR_WIDTH-1:0]   da_reg, cur_addr;
  logic [LENGTH_WIDTH-1:0] length_reg;
  logic [BEAT_WIDTH-1:0]   remaining;

  logic                    aw_held, w_held;
  logic [6:0]              aw_addr_q;
  logic [31:0]             w_data_q;

  logic                    aw_have, w_have, wr_commit, wr_mapped;
  logic [6:0]              wr_sel;
  logic [31:0]             wr_val;
  logic                    wr_dmacr, wr_dmasr, wr_da, wr_length;
  logic [LENGTH_WIDTH-1:0] wr_len_bytes;
  logic [LENGTH_WIDTH:0]   len_round;
  logic                    start_xfer, beat, last_by_count, end_beat, int_err_set;
  logic [31:0]             rd_data;
  logic                    rd_ok;
  logic                    unused_bits;

  // AW and W may arrive in either order; a half-captured request waits in aw_held/w_held.
  assign ctrl_awready = !aw_held && !ctrl_bvalid;
  assign ctrl_wready  = !w_held && !ctrl_bvalid;
  assign aw_have      = aw_held || (ctrl_awvalid && ctrl_awready);
  assign w_have       = w_held || (ctrl_wvalid && ctrl_wready);
  assign wr_commit    = aw_have && w_have;
  assign wr_sel       = aw_held ? aw_addr_q : ctrl_awaddr[6:0];
  assign wr_val       = w_held ? w_data_q : ctrl_wdata;
  assign wr_mapped    = (wr_sel == REG_DMACR) || (wr_sel == REG_DMASR) ||
                        (wr_sel == REG_DA) || (wr_sel == REG_LENGTH);
  assign wr_dmacr     = wr_commit && (wr_sel == REG_DMACR);
  assign wr_dmasr     = wr_commit && (wr_sel == REG_DMASR);
  assign wr_da        = wr_commit && (wr_sel == REG_DA);
  assign wr_length    = wr_commit && (wr_sel == REG_LENGTH);
  assign wr_len_bytes = wr_val[LENGTH_WIDTH-1:0];
  assign len_round    = {1'b0, wr_len_bytes} + (LENGTH_WIDTH+1)'(3);

  assign start_xfer    = wr_length && (state == ST_IDLE) && dmacr_rs && (wr_len_bytes != '0);
  assign in_tready     = (state == ST_TRANSFER) && dmacr_rs && mem_ready;
  assign beat          = in_tvalid && in_tready;
  assign last_by_count = (remaining == BEAT_WIDTH'(1));
  assign irq           = dmasr_ioc_irq && dmacr_ioc_en;

`ifdef USCOPE_DMA_SINK_TLAST_CHECK_EN
  assign end_beat    = beat && (in_tlast || last_by_count);
  assign int_err_set = beat && (in_tlast != last_by_count);
`else
  assign end_beat    = beat && last_by_count;
  assign int_err_set = 1'b0;
`endif

  assign unused_bits = ^{ctrl_awaddr[31:7], ctrl_araddr[31:7], in_tlast};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      ctrl_bvalid <= 1'b0;
      ctrl_bresp  <= RESP_OKAY;
    end else begin
      if (ctrl_bvalid && ctrl_bready) ctrl_bvalid <= 1'b0;
      if (wr_commit) begin
        aw_held     <= 1'b0;
        w_held      <= 1'b0;
        ctrl_bvalid <= 1'b1;
        ctrl_bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (ctrl_awvalid && ctrl_awready) begin
          aw_held   <= 1'b1;
          aw_addr_q <= ctrl_awaddr[6:0];
        end
        if (ctrl_wvalid && ctrl_wready) begin
          w_held   <= 1'b1;
          w_data_q <= ctrl_wdata;
        end
      end
    end
  end

  // Status bits are sticky; a hardware set in the same cycle as a W1C clear wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dmacr_rs      <= 1'b0;
      dmacr_ioc_en  <= 1'b0;
      dmasr_int_err <= 1'b0;
      dmasr_ioc_irq <= 1'b0;
      da_reg        <= '0;
      length_reg    <= '0;
    end else begin
      if (wr_dmacr) begin
        dmacr_rs     <= wr_val[0];
        dmacr_ioc_en <= wr_val[12];
      end
      if (wr_da) da_reg <= ADDR_WIDTH'(wr_val);
      if (wr_length) length_reg <= wr_len_bytes;
      dmasr_ioc_irq <= (state == ST_DONE) || (dmasr_ioc_irq && !(wr_dmasr && wr_val[12]));
      dmasr_int_err <= int_err_set || (dmasr_int_err && !(wr_dmasr && wr_val[4]));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_HALTED;
      cur_addr  <= '0;
      remaining <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      dma_done  <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      dma_done <= 1'b0;
      if (beat) begin
        mem_we    <= 1'b1;
        mem_addr  <= cur_addr;
        mem_data  <= in_tdata;
        cur_addr  <= cur_addr + ADDR_WIDTH'(4);
        remaining <= remaining - BEAT_WIDTH'(1);
      end
      case (state)
        ST_HALTED: if (dmacr_rs) state <= ST_IDLE;
        ST_IDLE: begin
          if (!dmacr_rs) begin
            state <= ST_HALTED;
          end else if (start_xfer) begin
            state     <= ST_TRANSFER;
            cur_addr  <= da_reg;
            remaining <= len_round[LENGTH_WIDTH:2];
          end
        end
        // Clearing RS aborts quietly; in_tready is already gated off by RS.
        ST_TRANSFER: begin
          if (!dmacr_rs) state <= ST_HALTED;
          else if (end_beat) state <= ST_DONE;
        end
        default: begin
          dma_done <= 1'b1;
          state    <= dmacr_rs ? ST_IDLE : ST_HALTED;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b1;
    case (ctrl_araddr[6:0])
      REG_DMACR:  rd_data = 32'({dmacr_ioc_en, 11'b0, dmacr_rs});
      REG_DMASR:  rd_data = 32'({dmasr_ioc_irq, 7'b0, dmasr_int_err, 2'b0,
                                 state == ST_IDLE, state == ST_HALTED});
      REG_DA:     rd_data = 32'(da_reg);
      REG_LENGTH: rd_data = 32'(length_reg);
      default:    rd_ok   = 1'b0;
    endcase
  end

  assign ctrl_arready = !ctrl_rvalid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_rvalid <= 1'b0;
      ctrl_rdata  <= '0;
      ctrl_rresp  <= RESP_OKAY;
    end else if (ctrl_arvalid && ctrl_arready) begin
      ctrl_rvalid <= 1'b1;
      ctrl_rdata  <= rd_data;
      ctrl_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (ctrl_rvalid && ctrl_rready) begin
      ctrl_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uscope_dma_sink.sv
// tb_uscope_dma_sink: randomized self-checking bench for uscope_dma_sink.
// Expected memory writes come from the DA/LENGTH rules: ceil(LENGTH/4) beats at DA + 4*i.
module tb_uscope_dma_sink;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ctrl_awaddr = '0, ctrl_wdata = '0, ctrl_araddr = '0;
  logic        ctrl_awvalid = 1'b0, ctrl_wvalid = 1'b0, ctrl_bready = 1'b0;
  logic        ctrl_arvalid = 1'b0, ctrl_rready = 1'b0;
  logic        ctrl_awready, ctrl_wready, ctrl_bvalid, ctrl_arready, ctrl_rvalid;
  logic [1:0]  ctrl_bresp, ctrl_rresp;
  logic [31:0] ctrl_rdata;
  logic [31:0] in_tdata = '0;
  logic        in_tvalid = 1'b0, in_tlast = 1'b0, mem_ready = 1'b1;
  logic        in_tready, mem_we, dma_done, irq;
  logic [31:0] mem_addr, mem_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] beat_data[$];
  int  done_cnt = 0, ready_cnt = 0, lat_err = 0, cyc = 0, done_cyc = 0, last_we_cyc = 0;
  bit  beat_prev = 1'b0;
  bit  xfer_busy = 1'b0;

  uscope_dma_sink dut (
    .clock(clock), .reset(reset),
    .ctrl_awaddr(ctrl_awaddr), .ctrl_awvalid(ctrl_awvalid), .ctrl_awready(ctrl_awready),
    .ctrl_wdata(ctrl_wdata), .ctrl_wvalid(ctrl_wvalid), .ctrl_wready(ctrl_wready),
    .ctrl_bresp(ctrl_bresp), .ctrl_bvalid(ctrl_bvalid), .ctrl_bready(ctrl_bready),
    .ctrl_araddr(ctrl_araddr), .ctrl_arvalid(ctrl_arvalid), .ctrl_arready(ctrl_arready),
    .ctrl_rdata(ctrl_rdata), .ctrl_rresp(ctrl_rresp), .ctrl_rvalid(ctrl_rvalid),
    .ctrl_rready(ctrl_rready),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .dma_done(dma_done), .irq(irq)
  );

  always #5 clock = ~clock;

  // Memory-side observer: every mem_we must follow an accepted beat by exactly one cycle.
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      beat_prev = 1'b0;
    end else begin
      if (mem_we !== beat_prev) lat_err++;
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_data);
        last_we_cyc = cyc;
      end
      if (dma_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (in_tready) ready_cnt++;
      beat_prev = in_tvalid && in_tready;
    end
  end

  task automatic clear_obs();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0; ready_cnt = 0; lat_err = 0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int mode;
    bit awd, wd, aw_hs, w_hs, got;
    mode = $urandom_range(0, 2);
    awd = 0; wd = 0; got = 0; resp = 2'b11;
    ctrl_awaddr = a; ctrl_wdata = d;
    ctrl_awvalid = (mode != 2);
    ctrl_wvalid  = (mode != 1);
    for (int t = 0; t < 50 && !(awd && wd); t++) begin
      @(negedge clock);
      aw_hs = ctrl_awvalid && ctrl_awready;
      w_hs  = ctrl_wvalid && ctrl_wready;
      @(posedge clock); #1;
      if (aw_hs) begin awd = 1; ctrl_awvalid = 0; end
      if (w_hs) begin wd = 1; ctrl_wvalid = 0; end
      if (awd && !wd) ctrl_wvalid = 1;
      if (wd && !awd) ctrl_awvalid = 1;
    end
    ctrl_awvalid = 0; ctrl_wvalid = 0;
    ctrl_bready = 1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clock);
      if (ctrl_bvalid) begin got = 1; resp = ctrl_bresp; end
    end
    @(posedge clock); #1;
    ctrl_bready = 0;
    checks++;
    if (!(awd && wd && got)) begin
      failures++;
      $display("[TB] FAIL axi_write_handshake addr=%h got=0 required=1", a);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ard, ar_hs, got;
    ard = 0; got = 0; d = '1; resp = 2'b11;
    ctrl_araddr = a; ctrl_arvalid = 1; ctrl_rready = 1;
    for (int t = 0; t < 20 && !ard; t++) begin
      @(negedge clock);
      ar_hs = ctrl_arvalid && ctrl_arready;
      @(posedge clock); #1;
      if (ar_hs) begin ard = 1; ctrl_arvalid = 0; end
    end
    ctrl_arvalid = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clock);
      if (ctrl_rvalid) begin got = 1; d = ctrl_rdata; resp = ctrl_rresp; end
    end
    @(posedge clock); #1;
    ctrl_rready = 0;
    checks++;
    if (!(ard && got)) begin
      failures++;
      $display("[TB] FAIL axi_read_handshake addr=%h got=0 required=1", a);
    end
  endtask

  // Drives beat_data[0..n-1] with random idle gaps; tlast on index tlast_at.
  task automatic send_beats(input int n, input int tlast_at);
    bit hs, timed_out;
    timed_out = 0;
    for (int i = 0; i < n && !timed_out; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_tvalid = 0;
        @(posedge clock); #1;
      end
      in_tvalid = 1; in_tdata = beat_data[i]; in_tlast = (i == tlast_at);
      hs = 0;
      for (int t = 0; t < 200 && !hs; t++) begin
        @(negedge clock);
        hs = in_tvalid && in_tready;
        @(posedge clock); #1;
      end
      if (!hs) timed_out = 1;
    end
    in_tvalid = 0; in_tlast = 0;
    checks++;
    if (timed_out) begin
      failures++;
      $display("[TB] FAIL stream_accept got=stalled required=accepted");
    end
  endtask

  task automatic wait_done();
    for (int c = 0; c < 200 && done_cnt == 0; c++) @(negedge clock);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] da, input logic [31:0] len);
    logic [1:0] r;
    axi_write(32'h4040_0034, 32'h1010, r);
    axi_write(32'h4040_0048, da, r);
    axi_write(32'h4040_0058, len, r);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({in_tready, mem_we, mem_addr, mem_data, dma_done, irq, ctrl_bvalid, ctrl_rvalid} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b/%b/%h/%h/%b/%b required=all zero",
               in_tready, mem_we, mem_addr, mem_data, dma_done, irq);
    end
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    axi_read(32'h4040_0034, d, r);
    checks++;
    if (d !== 32'h1 || r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_dmasr got=%h/%b required=00000001/00", d, r);
    end
    axi_read(32'h4040_0058, d, r);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_length got=%h required=0", d);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [1:0]  r;
    int mism;
    axi_write(32'h4040_0030, 32'h1, r);
    checks++;
    if (r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL basic_dmacr_resp got=%b required=00", r);
    end
    repeat (2) @(posedge clock);
    #1;
    clear_obs();
    beat_data.delete();
    for (int i = 0; i < 4; i++) beat_data.push_back(32'hA0 + 32'(i));
    start_xfer(32'h1000_0000, 32'd16);
    send_beats(4, 3);
    wait_done();
    mism = 0;
    for (int i = 0; i < wr_addr.size() && i < 4; i++)
      if (wr_addr[i] !== 32'h1000_0000 + 32'(4 * i) || wr_data[i] !== 32'hA0 + 32'(i)) mism++;
    checks++;
    if (wr_addr.size() != 4 || mism != 0) begin
      failures++;
      $display("[TB] FAIL basic_writes got=%0d writes/%0d bad required=4 writes/0 bad", wr_addr.size(), mism);
    end
    checks++;
    if (done_cnt != 1 || lat_err != 0 || done_cyc != last_we_cyc + 1) begin
      failures++;
      $display("[TB] FAIL basic_done got=%0d pulses lat_err=%0d gap=%0d required=1/0/1",
               done_cnt, lat_err, done_cyc - last_we_cyc);
    end
    axi_read(32'h4040_0034, d, r);
    checks++;
    if (d !== 32'h1002) begin
      failures++;
      $display("[TB] FAIL basic_dmasr got=%h required=00001002", d);
    end
  endtask

  task automatic test_random_transfers();
    logic [31:0] da;
    int len, n, mism;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        da = 32'hFFFF_FFF8; len = 16;
      end else begin
        da = $urandom & 32'hFFFF_FFFC; len = $urandom_range(1, 48);
      end
      n = (len + 3) / 4;
      clear_obs();
      beat_data.delete();
      for (int i = 0; i < n; i++) beat_data.push_back($urandom);
      start_xfer(da, 32'(len));
      send_beats(n, n - 1);
      wait_done();
      mism = 0;
      for (int i = 0; i < wr_addr.size() && i < n; i++)
        if (wr_addr[i] !== da + 32'(4 * i) || wr_data[i] !== beat_data[i]) mism++;
      checks++;
      if (wr_addr.size() != n || mism != 0) begin
        failures++;
        $display("[TB] FAIL random_writes it=%0d len=%0d got=%0d writes/%0d bad required=%0d/0",
                 it, len, wr_addr.size(), mism, n);
      end
      checks++;
      if (done_cnt != 1 || lat_err != 0 || done_cyc != last_we_cyc + 1) begin
        failures++;
        $display("[TB] FAIL random_done it=%0d got=%0d pulses lat_err=%0d required=1/0", it, done_cnt, lat_err);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] da;
    int mism;
    da = $urandom & 32'hFFFF_FFFC;
    clear_obs();
    beat_data.delete();
    for (int i = 0; i < 8; i++) beat_data.push_back($urandom);
    start_xfer(da, 32'd32);
    xfer_busy = 1;
    fork
      begin send_beats(8, 7); xfer_busy = 0; end
      begin
        while (xfer_busy) begin
          @(posedge clock); #1;
          mem_ready = ~mem_ready;
        end
      end
    join
    mem_ready = 1;
    wait_done();
    mism = 0;
    for (int i = 0; i < wr_addr.size() && i < 8; i++)
      if (wr_addr[i] !== da + 32'(4 * i) || wr_data[i] !== beat_data[i]) mism++;
    checks++;
    if (wr_addr.size() != 8 || mism != 0 || done_cnt != 1) begin
      failures++;
      $display("[TB] FAIL backpressure got=%0d writes/%0d bad/%0d done required=8/0/1",
               wr_addr.size(), mism, done_cnt);
    end
  endtask

  task automatic test_length_rounding();
    logic [31:0] d;
    logic [1:0]  r;
    clear_obs();
    beat_data.delete();
    for (int i = 0; i < 2; i++) beat_data.push_back($urandom);
    start_xfer(32'h2000_0100, 32'd6);
    send_beats(2, 1);
    wait_done();
    checks++;
    if (wr_addr.size() != 2 || done_cnt != 1 ||
        (wr_addr.size() == 2 && (wr_addr[1] !== 32'h2000_0104 || wr_data[1] !== beat_data[1]))) begin
      failures++;
      $display("[TB] FAIL length6 got=%0d writes/%0d done required=2/1", wr_addr.size(), done_cnt);
    end
    clear_obs();
    start_xfer(32'h2000_0200, 32'd0);
    in_tvalid = 1; in_tdata = $urandom;
    repeat (20) @(posedge clock);
    #1;
    in_tvalid = 0;
    checks++;
    if (ready_cnt != 0 || done_cnt != 0 || wr_addr.size() != 0) begin
      failures++;
      $display("[TB] FAIL length0 got=%0d ready/%0d done required=0/0", ready_cnt, done_cnt);
    end
    axi_read(32'h4040_0034, d, r);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("[TB] FAIL length0_dmasr got=%h required=00000002", d);
    end
  endtask

  task automatic test_abort();
    logic [31:0] d, da;
    logic [1:0]  r;
    int mism;
    da = $urandom & 32'hFFFF_FFFC;
    clear_obs();
    beat_data.delete();
    for (int i = 0; i < 8; i++) beat_data.push_back($urandom);
    start_xfer(da, 32'd32);
    send_beats(3, -1);
    axi_write(32'h4040_0030, 32'h0, r);
    repeat (4) @(posedge clock);
    #1;
    ready_cnt = 0;
    in_tvalid = 1; in_tdata = beat_data[3];
    repeat (10) @(posedge clock);
    #1;
    in_tvalid = 0;
    mism = 0;
    for (int i = 0; i < wr_addr.size() && i < 3; i++)
      if (wr_addr[i] !== da + 32'(4 * i) || wr_data[i] !== beat_data[i]) mism++;
    checks++;
    if (wr_addr.size() != 3 || mism != 0 || done_cnt != 0 || ready_cnt != 0) begin
      failures++;
      $display("[TB] FAIL abort got=%0d writes/%0d bad/%0d done/%0d ready required=3/0/0/0",
               wr_addr.size(), mism, done_cnt, ready_cnt);
    end
    axi_read(32'h4040_0034, d, r);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL abort_dmasr got=%h required=00000001", d);
    end
  endtask

`ifdef USCOPE_DMA_SINK_TLAST_CHECK_EN
  task automatic test_tlast_check();
    logic [31:0] d;
    logic [1:0]  r;
    clear_obs();
    beat_data.delete();
    for (int i = 0; i < 5; i++) beat_data.push_back($urandom);
    start_xfer(32'h3000_0000, 32'd32);
    send_beats(5, 4);
    wait_done();
    checks++;
    if (wr_addr.size() != 5 || done_cnt != 1) begin
      failures++;
      $display("[TB] FAIL tlast_early got=%0d writes/%0d done required=5/1", wr_addr.size(), done_cnt);
    end
    axi_read(32'h4040_0034, d, r);
    checks++;
    if (d !== 32'h1012) begin
      failures++;
      $display("[TB] FAIL tlast_interr got=%h required=00001012", d);
    end
    axi_write(32'h4040_0034, 32'h10, r);
    axi_read(32'h4040_0034, d, r);
    checks++;
    if (d !== 32'h1002) begin
      failures++;
      $display("[TB] FAIL tlast_interr_clear got=%h required=00001002", d);
    end
  endtask
`endif

  task automatic test_registers();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h4040_0030, 32'h1001, r);
    repeat (2) @(posedge clock);
    #1;
    axi_read(32'h4040_0030, d, r);
    checks++;
    if (d !== 32'h1001 || r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL dmacr_readback got=%h/%b required=00001001/00", d, r);
    end
    clear_obs();
    beat_data.delete();
    beat_data.push_back($urandom);
    start_xfer(32'h0000_0040, 32'd4);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_before got=%b required=0", irq);
    end
    send_beats(1, 0);
    wait_done();
    checks++;
    if (irq !== 1'b1 || done_cnt != 1) begin
      failures++;
      $display("[TB] FAIL irq_after_done got=%b/%0d required=1/1", irq, done_cnt);
    end
    axi_write(32'h4040_0034, 32'h1000, r);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_cleared got=%b required=0", irq);
    end
    axi_write(32'h4040_0040, $urandom, r);
    checks++;
    if (r !== 2'b10) begin
      failures++;
      $display("[TB] FAIL unmapped_write got=%b required=10", r);
    end
    axi_read(32'h4040_0040, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      failures++;
      $display("[TB] FAIL unmapped_read got=%h/%b required=0/10", d, r);
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] d;
    logic [1:0]  r;
    clear_obs();
    beat_data.delete();
    for (int i = 0; i < 8; i++) beat_data.push_back($urandom);
    start_xfer(32'h4000_0000, 32'd32);
    send_beats(2, -1);
    in_tvalid = 1; in_tdata = beat_data[2];
    @(negedge clock);
    #2;
    reset = 0;
    #1;
    checks++;
    if ({in_tready, mem_we, mem_addr, mem_data, dma_done, irq, ctrl_bvalid, ctrl_rvalid} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid got=%b/%b/%h/%h/%b/%b required=all zero",
               in_tready, mem_we, mem_addr, mem_data, dma_done, irq);
    end
    in_tvalid = 0;
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    axi_read(32'h4040_0030, d, r);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_dmacr got=%h required=0", d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_random_transfers();
    test_backpressure();
    test_length_rounding();
`ifdef USCOPE_DMA_SINK_TLAST_CHECK_EN
    test_tlast_check();
`endif
    test_abort();
    test_registers();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
